// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and default width.
package timer_pkg;

    localparam int TIMER_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

endpackage

// File: rtl/timer_fsm.sv
// Control FSM for countdown_timer: decides load/decrement strobes and the registered expiry pulse.
module timer_fsm
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       valid,
    input  logic       value_nz,
    input  logic       count_one,
    input  logic       reload_nz,
    output logic [1:0] state,
    output logic       load,
    output logic       dec,
    output logic       trigger
);

    timer_state_t state_q;
    timer_state_t state_d;
    logic         trigger_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            trigger <= 1'b0;
        end else begin
            state_q <= state_d;
            trigger <= trigger_d;
        end
    end

    // A load always wins, even over the single DONE cycle; expiry stays in RUN when a reload is armed.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        dec       = 1'b0;
        trigger_d = 1'b0;
        if (valid) begin
            load    = 1'b1;
            state_d = value_nz ? RUN : IDLE;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (enable) begin
                        dec = 1'b1;
                        if (count_one) begin
                            trigger_d = 1'b1;
                            state_d   = reload_nz ? RUN : DONE;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with a single-cycle expiry pulse.
// Define TIMER_AUTORELOAD_EN to make the timer periodic using the last loaded value.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] value,
    input  logic             valid,
    output logic             trigger,
    output logic [WIDTH-1:0] count
);

    logic [1:0]       state_bits;
    logic             load;
    logic             dec;
    logic             running;
    logic             count_one;
    logic             reload_nz;
    logic [WIDTH-1:0] expiry_value;

    assign count_one = (count == WIDTH'(1));
    assign running   = (timer_state_t'(state_bits) == RUN);

`ifdef TIMER_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            reload_q <= '0;
        end else if (load) begin
            reload_q <= value;
        end
    end

    assign reload_nz    = |reload_q;
    assign expiry_value = reload_q;
`else
    assign reload_nz    = 1'b0;
    assign expiry_value = '0;
`endif

    timer_fsm u_fsm (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .valid     (valid),
        .value_nz  (|value),
        .count_one (count_one),
        .reload_nz (reload_nz),
        .state     (state_bits),
        .load      (load),
        .dec       (dec),
        .trigger   (trigger)
    );

    // The expiry step lands on the reload value (or zero), so the count never wraps.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (dec && running) begin
            count <= count_one ? expiry_value : (count - WIDTH'(1));
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer; expectations come from a behavioural model of the timer.
module tb_countdown_timer;

    localparam int W = 5;

    logic         clk;
    logic         reset;
    logic         enable;
    logic [W-1:0] value;
    logic         valid;
    logic         trigger;
    logic [W-1:0] count;

    typedef struct {
        int cnt;
        int trig;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: 0 idle, 1 run, 2 done
    int m_count  = 0;
    int m_trig   = 0;
    int m_state  = 0;
    int m_reload = 0;

    countdown_timer #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .value   (value),
        .valid   (valid),
        .trigger (trigger),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelStep(input bit rst_n, input bit en, input bit vld, input int val);
        bit auto_reload;
`ifdef TIMER_AUTORELOAD_EN
        auto_reload = 1'b1;
`else
        auto_reload = 1'b0;
`endif
        if (!rst_n) begin
            m_count = 0; m_trig = 0; m_state = 0; m_reload = 0;
        end else if (vld) begin
            m_count  = val;
            m_trig   = 0;
            m_reload = val;
            m_state  = (val != 0) ? 1 : 0;
        end else if (m_state == 1 && en) begin
            if (m_count == 1) begin
                m_trig = 1;
                if (auto_reload && m_reload != 0) begin
                    m_count = m_reload;
                end else begin
                    m_count = 0;
                    m_state = 2;
                end
            end else begin
                m_count = m_count - 1;
                m_trig  = 0;
            end
        end else begin
            if (m_state == 2) m_state = 0;
            m_trig = 0;
        end
    endtask

    // Drive one cycle of inputs on the falling edge and queue what the next rising edge must produce.
    task automatic applyStimulus(input bit rst_n, input bit en, input bit vld, input int val, input int cycles = 1);
        exp_t e;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            reset  = rst_n;
            enable = en;
            valid  = vld;
            value  = W'(val);
            modelStep(rst_n, en, vld, val);
            e.cnt  = m_count;
            e.trig = m_trig;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("count", int'(count), e.cnt);
                checkOutput("trigger", int'(trigger), e.trig);
            end
        end
    end

    initial begin
        reset  = 1'b0;
        enable = 1'b0;
        valid  = 1'b0;
        value  = '0;

        // Reset, then enable without a load: stays at zero, no pulse
        applyStimulus(0, 0, 0, 0, 2);
        applyStimulus(1, 1, 0, 0, 3);

        // Load 10 and count all the way down, then keep enabling
        applyStimulus(1, 0, 1, 10);
        applyStimulus(1, 1, 0, 0, 14);

        // Pause at 6, then resume
        applyStimulus(1, 0, 1, 10);
        applyStimulus(1, 1, 0, 0, 4);
        applyStimulus(1, 0, 0, 0, 2);
        applyStimulus(1, 1, 0, 0, 8);

        // Reset mid-count at 3
        applyStimulus(1, 0, 1, 10);
        applyStimulus(1, 1, 0, 0, 7);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(1, 1, 0, 0, 3);

        // Load while enabled, then load of zero
        applyStimulus(1, 1, 1, 5);
        applyStimulus(1, 1, 0, 0, 7);
        applyStimulus(1, 1, 1, 0);
        applyStimulus(1, 1, 0, 0, 3);

        // Load during the expiry cycle overrides it
        applyStimulus(1, 0, 1, 2);
        applyStimulus(1, 1, 0, 0, 2);
        applyStimulus(1, 1, 1, 3);
        applyStimulus(1, 1, 0, 0, 5);

        // Maximum value and a count of one
        applyStimulus(1, 0, 1, 31);
        applyStimulus(1, 1, 0, 0, 33);
        applyStimulus(1, 0, 1, 1);
        applyStimulus(1, 1, 0, 0, 3);

        // Periodic run (one-shot without the reload feature)
        applyStimulus(1, 0, 1, 5);
        applyStimulus(1, 1, 0, 0, 16);

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            applyStimulus(($urandom_range(0, 29) != 0), ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 11) == 0), int'($urandom_range(0, 31)));
        end
        applyStimulus(1, 0, 0, 0, 2);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) checkOutput("drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter with expiry pulse. A value is captured on a `valid` strobe. The counter then decrements by one per clock while `enable` is high, and raises a single-cycle `trigger` when it reaches zero. It sits as a small peripheral in the control path, and its current count is exposed for status readback.

## Interface
- `WIDTH`, default 5: counter and load-value width.
- `clk`  in  1: sole clock; all logic updates on the rising edge.
- `reset`  in  1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `enable`  in  1: countdown enable; high means decrement each cycle.
- `value`  in  WIDTH: load value, sampled when `valid`=1.
- `valid`  in  1: load strobe, single cycle or held.
- `trigger`  out  1: registered expiry pulse.
- `count`  out  WIDTH: registered current count.

## Operation
- FSM states:
  - IDLE: `count`=0, not counting.
  - RUN: `count`>0.
  - DONE: expiry cycle, `trigger`=1.
- Priority per edge: `reset` low, then `valid`, then `enable`, then hold.
- Reset (`reset`=0 at an edge): `count`<=0, `trigger`<=0, state<=IDLE.
- Load (`valid`=1): `count`<=`value`, `trigger`<=0.
  - State becomes RUN if `value`≠0, else IDLE.
  - Load wins over `enable` in the same cycle, and also overrides DONE.
- Decrement (`enable`=1, `valid`=0, `count`>0): `count`<=`count`-1.
- Expiry: when the decrement takes `count` from 1 to 0, `trigger`<=1 at that same edge. State becomes DONE.
- DONE lasts exactly one cycle, then state<=IDLE and `trigger`<=0, regardless of `enable`.
- Pause (`enable`=0 in RUN): `count` holds and there is no trigger. Resuming continues from the held value.
- At zero: `count` saturates at 0 and never wraps to 2^WIDTH-1. Further `enable` cycles in IDLE do nothing and produce no further trigger.
- Load of 0: `count`=0, no trigger pulse.
- Reset mid-count: immediately returns to IDLE with `count`=0. A pending expiry is discarded.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Load latency: `count` equals `value` in the cycle after the edge where `valid`=1.
- Countdown: a load of N, followed by continuous `enable`, reaches `count`=0 after N enabled edges.
- The `trigger` high cycle coincides with the first cycle in which `count` reads 0.
- The `trigger` pulse width is always 1 cycle.
- Outputs are defined from the first edge with `reset` low: `count`=0, `trigger`=0.

## Configuration
- `TIMER_AUTORELOAD_EN` defined:
  - A reload register (WIDTH bits, reset 0) captures `value` on every load.
  - At the expiry edge, `count`<=reload value instead of 0 (if the reload value ≠0), `trigger` still pulses for 1 cycle, and the state stays RUN. This makes the timer periodic with period = reload value.
  - A reload value of 0 behaves as one-shot.
- Not defined: one-shot behaviour exactly as above. No reload register is instantiated.

## Structure
- Package `timer_pkg`:
  - FSM state enum {IDLE, RUN, DONE}.
  - Default `WIDTH` constant.
- Sub-module `timer_fsm`:
  - Inputs: `clk`, `reset`, `enable`, `valid`, a load-value-nonzero flag and a count-equals-one flag.
  - Outputs: state, load strobe, decrement strobe and `trigger`.
- Top level holds the count (and reload) registers and the datapath.

## Test plan
- Reset held low for 2 cycles → `count`=0, `trigger`=0. Then `enable`=1 with no load → `count` stays 0, no trigger.
- `value`=10 with `valid` for 1 cycle, then `enable`=1 → `count` reads 10,9,…,1,0. `trigger`=1 only in the first cycle `count`=0, then it stays 0 while `enable` remains high.
- Load 10, enable 4 cycles (`count`=6), `enable`=0 for 2 cycles → `count` holds 6. Re-enable → 5,4,… and the trigger occurs 6 enabled cycles after resume.
- Mid-count at `count`=3, drive `reset` low for 1 cycle → `count`=0, no trigger. Re-enable → stays 0.
- `value`=5 with `valid` while `enable`=1 → load wins, `count`=5. The trigger occurs 5 cycles later. A load of 0 → no trigger.
- With `TIMER_AUTORELOAD_EN`: load 5, enable continuously → `trigger` every 5 cycles, `count` sequence 5,4,3,2,1,5,4,… with no wrap or underflow.
